// File: rtl/writeback_unit_pkg.sv
// Shared writeback types and register-file constants.
// Used by writeback_unit and wb_fifo.
package writeback_unit_pkg;

    localparam int RegAddrBits = 5;
    localparam int DataBusBits = 32;
    localparam int NumRegs     = 1 << RegAddrBits;
    localparam int WbFifoDepth = 4;

    localparam logic [RegAddrBits-1:0] RegZero  = '0;
    localparam logic [DataBusBits-1:0] DataZero = '0;

    typedef logic [RegAddrBits-1:0] reg_addr_t;
    typedef logic [DataBusBits-1:0] data_t;

    typedef struct packed {
        reg_addr_t rd;
        data_t     data;
    } wb_entry_t;

    function automatic logic is_zero(input reg_addr_t a);
        return a == RegZero;
    endfunction

endpackage

// File: rtl/writeback_unit_wb_fifo.sv
// Load-response FIFO feeding the writeback arbiter.
// Push while full is taken only together with a pop.
module wb_fifo
    import writeback_unit_pkg::*;
#(
    parameter int DEPTH = WbFifoDepth,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit tells full from empty.
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: ALU/load arbitration, pending-load scoreboard.
// Define WB_BYPASS_EN to forward the write stage into rs*_data.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter  int DEPTH = WbFifoDepth,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    input  logic [RegAddrBits-1:0] issue_rd,
    output logic                   issue_ready,
    input  logic                   ld_valid,
    input  logic [RegAddrBits-1:0] ld_rd,
    input  logic [DataBusBits-1:0] ld_data,
    output logic                   ld_ready,
    input  logic                   alu_valid,
    input  logic [RegAddrBits-1:0] alu_rd,
    input  logic [DataBusBits-1:0] alu_data,
    output logic                   alu_ready,
    input  logic [RegAddrBits-1:0] rs1_addr,
    input  logic [RegAddrBits-1:0] rs2_addr,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    input  logic [DataBusBits-1:0] rf_rdata1_i,
    input  logic [DataBusBits-1:0] rf_rdata2_i,
    output logic [DataBusBits-1:0] rs1_data,
    output logic [DataBusBits-1:0] rs2_data,
    output logic                   rf_we,
    output logic [RegAddrBits-1:0] rf_waddr,
    output logic [DataBusBits-1:0] rf_wdata
);

    logic [NumRegs-1:0] pending;
    logic [NumRegs-1:0] pend_set;
    logic [NumRegs-1:0] pend_clr;
    logic               wb_is_load;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               alu_fire;
    logic               sel_valid;
    wb_entry_t          ld_entry;
    wb_entry_t          head;
    wb_entry_t          sel;

    assign ld_entry    = '{rd: ld_rd, data: ld_data};
    assign ld_ready    = !fifo_full;
    assign issue_ready = !pending[issue_rd];
    assign alu_ready   = !fifo_full &&
                         (is_zero(alu_rd) || !pending[alu_rd]);

    assign push     = ld_valid && ld_ready;
    assign alu_fire = alu_valid && alu_ready;
    assign pop      = !alu_fire && !fifo_empty;

    wb_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (ld_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        sel_valid = 1'b1;
        sel       = head;
        unique case (1'b1)
            alu_fire: sel = '{rd: alu_rd, data: alu_data};
            pop:      sel = head;
            default:  sel_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we      <= 1'b0;
            rf_waddr   <= RegZero;
            rf_wdata   <= DataZero;
            wb_is_load <= 1'b0;
        end else begin
            rf_we <= sel_valid && !is_zero(sel.rd);
            if (sel_valid) begin
                rf_waddr   <= sel.rd;
                rf_wdata   <= sel.data;
                wb_is_load <= !alu_fire;
            end
        end
    end

    // Clear lands on the same edge the register file takes the load.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (issue_valid && issue_ready && !is_zero(issue_rd))
            pend_set[issue_rd] = 1'b1;
        if (rf_we && wb_is_load)
            pend_clr[rf_waddr] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pending <= '0;
        else
            pending <= (pending & ~pend_clr) | pend_set;
    end

`ifdef WB_BYPASS_EN
    logic hit1;
    logic hit2;

    assign hit1 = rf_we && rf_waddr == rs1_addr && !is_zero(rs1_addr);
    assign hit2 = rf_we && rf_waddr == rs2_addr && !is_zero(rs2_addr);

    assign rs1_data = hit1 ? rf_wdata : rf_rdata1_i;
    assign rs2_data = hit2 ? rf_wdata : rf_rdata2_i;

    assign rs1_busy = pending[rs1_addr] && !is_zero(rs1_addr) &&
                      !(hit1 && wb_is_load);
    assign rs2_busy = pending[rs2_addr] && !is_zero(rs2_addr) &&
                      !(hit2 && wb_is_load);
`else
    assign rs1_data = rf_rdata1_i;
    assign rs2_data = rf_rdata2_i;

    assign rs1_busy = pending[rs1_addr] && !is_zero(rs1_addr);
    assign rs2_busy = pending[rs2_addr] && !is_zero(rs2_addr);
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized bench for writeback_unit with a queue-based model.
// Honours WB_BYPASS_EN the same way as the design.
`timescale 1ns/1ps
module tb_writeback_unit;
    import writeback_unit_pkg::*;

    localparam int DEPTH = WbFifoDepth;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [31:0] rf_rdata1_i;
    logic [31:0] rf_rdata2_i;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always #5 clk = ~clk;

    writeback_unit dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rf_rdata1_i (rf_rdata1_i),
        .rf_rdata2_i (rf_rdata2_i),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // Model: pending bits, response queue, and the write stage.
    typedef struct {
        bit [4:0]  rd;
        bit [31:0] data;
    } resp_t;

    bit        m_pend [32];
    resp_t     m_q [$];
    bit        m_we;
    bit        m_load;
    bit [4:0]  m_waddr;
    bit [31:0] m_wdata;
    bit [4:0]  outst [$];

    task automatic m_clear();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_q.delete();
        m_we    = 1'b0;
        m_load  = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    always @(negedge clk) begin
        bit        full;
        bit        alu_ok;
        bit        iss_ok;
        bit        fire;
        bit        popped;
        bit        b1;
        bit        b2;
        bit [31:0] d1;
        bit [31:0] d2;
        resp_t     h;
        if (reset !== 1'b1) begin
            m_clear();
            chk("rst_we", rf_we, 0);
            chk("rst_ldrdy", ld_ready, 1);
        end else begin
            full   = m_q.size() == DEPTH;
            alu_ok = !full && (alu_rd == 0 || !m_pend[alu_rd]);
            iss_ok = !m_pend[issue_rd];
            b1 = rs1_addr != 0 && m_pend[rs1_addr];
            b2 = rs2_addr != 0 && m_pend[rs2_addr];
            d1 = rf_rdata1_i;
            d2 = rf_rdata2_i;
`ifdef WB_BYPASS_EN
            if (m_we && m_waddr == rs1_addr && rs1_addr != 0) begin
                d1 = m_wdata;
                if (m_load) b1 = 1'b0;
            end
            if (m_we && m_waddr == rs2_addr && rs2_addr != 0) begin
                d2 = m_wdata;
                if (m_load) b2 = 1'b0;
            end
`endif
            chk("ld_ready", ld_ready, !full);
            chk("alu_ready", alu_ready, alu_ok);
            chk("issue_ready", issue_ready, iss_ok);
            chk("rs1_busy", rs1_busy, b1);
            chk("rs2_busy", rs2_busy, b2);
            chk("rs1_data", rs1_data, d1);
            chk("rs2_data", rs2_data, d2);
            chk("rf_we", rf_we, m_we);
            if (m_we) begin
                chk("rf_waddr", rf_waddr, m_waddr);
                chk("rf_wdata", rf_wdata, m_wdata);
            end
            fire = alu_valid && alu_ok;
            if (m_we && m_load) m_pend[m_waddr] = 1'b0;
            if (issue_valid && iss_ok && issue_rd != 0)
                m_pend[issue_rd] = 1'b1;
            popped = !fire && m_q.size() > 0;
            if (popped) h = m_q.pop_front();
            if (ld_valid && !full) m_q.push_back('{ld_rd, ld_data});
            if (fire) begin
                m_we    = alu_rd != 0;
                m_load  = 1'b0;
                m_waddr = alu_rd;
                m_wdata = alu_data;
            end else if (popped) begin
                m_we    = h.rd != 0;
                m_load  = 1'b1;
                m_waddr = h.rd;
                m_wdata = h.data;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        issue_valid = 0;
        ld_valid    = 0;
        alu_valid   = 0;
    endtask

    initial begin
        reset       = 1;
        idle();
        issue_rd    = 0;
        ld_rd       = 0;
        ld_data     = 0;
        alu_rd      = 0;
        alu_data    = 0;
        rs1_addr    = 0;
        rs2_addr    = 0;
        rf_rdata1_i = 32'h1111_0000;
        rf_rdata2_i = 32'h2222_0000;
        #1 reset = 0;
        repeat (2) cyc();
        reset = 1;
        cyc();

        // ALU write, then ALU to x0
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
        #1 chk("t2_alurdy", alu_ready, 1);
        cyc(); alu_valid = 0;
        #1;
        chk("t2_we", rf_we, 1);
        chk("t2_waddr", rf_waddr, 5);
        chk("t2_wdata", rf_wdata, 32'h1234);
        alu_valid = 1; alu_rd = 0;
        cyc(); alu_valid = 0;
        #1 chk("t2_x0_we", rf_we, 0);

        // Load RAW on x7
        issue_valid = 1; issue_rd = 7;
        cyc(); issue_valid = 0; rs1_addr = 7;
        #1 chk("t3_busy", rs1_busy, 1);
        ld_valid = 1; ld_rd = 7; ld_data = 32'hABCD;
        cyc(); ld_valid = 0;
        #1;
        chk("t3_we0", rf_we, 0);
        chk("t3_busy_q", rs1_busy, 1);
        cyc();
        #1;
        chk("t3_we", rf_we, 1);
        chk("t3_waddr", rf_waddr, 7);
        chk("t3_wdata", rf_wdata, 32'hABCD);
`ifdef WB_BYPASS_EN
        chk("t3_busy_byp", rs1_busy, 0);
        chk("t3_data_byp", rs1_data, 32'hABCD);
`else
        chk("t3_busy_land", rs1_busy, 1);
`endif
        cyc();
        #1 chk("t3_busy_clr", rs1_busy, 0);
        rs1_addr = 0;

        // WAW on x9
        issue_valid = 1; issue_rd = 9;
        cyc();
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        #1;
        chk("t4_alurdy", alu_ready, 0);
        chk("t4_issrdy", issue_ready, 0);
        issue_valid = 0;
        ld_valid = 1; ld_rd = 9; ld_data = 32'h55;
        cyc(); ld_valid = 0;
        #1 chk("t4_hold0", alu_ready, 0);
        cyc();
        #1;
        chk("t4_ldwe", rf_we, 1);
        chk("t4_lddata", rf_wdata, 32'h55);
        chk("t4_hold1", alu_ready, 0);
        cyc();
        #1 chk("t4_release", alu_ready, 1);
        cyc(); alu_valid = 0;
        #1 chk("t4_aluw", rf_wdata, 32'h99);

        // FIFO fills while ALU wins, then drains in order
        alu_valid = 1; alu_rd = 10; alu_data = 32'hA0;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_rd = 5'(11 + i); ld_data = 32'(100 + i);
            cyc();
        end
        ld_valid = 0;
        #1;
        chk("t5_ldrdy", ld_ready, 0);
        chk("t5_alurdy", alu_ready, 0);
        alu_valid = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            #1;
            chk("t5_we", rf_we, 1);
            chk("t5_order", rf_waddr, 11 + i);
            chk("t5_data", rf_wdata, 100 + i);
        end
        alu_valid = 1; alu_rd = 10; alu_data = 32'hA1;
        #1 chk("t5_alu_after", alu_ready, 1);
        cyc(); alu_valid = 0;
        #1 chk("t5_alu_w", rf_wdata, 32'hA1);

        // ALU x3 beats FIFO head x4
        ld_valid = 1; ld_rd = 4; ld_data = 32'h44;
        cyc(); ld_valid = 0;
        alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
        cyc(); alu_valid = 0;
        #1;
        chk("t6_first", rf_waddr, 3);
        chk("t6_first_d", rf_wdata, 32'h33);
        cyc();
        #1;
        chk("t6_second", rf_waddr, 4);
        chk("t6_second_d", rf_wdata, 32'h44);

        // Async reset with 3 queued responses and x8 pending
        issue_valid = 1; issue_rd = 8;
        cyc(); issue_valid = 0;
        alu_valid = 1; alu_rd = 20; alu_data = 32'h1;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1; ld_rd = 5'(21 + i); ld_data = 32'(i);
            cyc();
        end
        ld_valid = 0; alu_valid = 0;
        reset = 0; rs1_addr = 8;
        #1;
        chk("t1_we", rf_we, 0);
        chk("t1_ldrdy", ld_ready, 1);
        chk("t1_waddr", rf_waddr, 0);
        chk("t1_wdata", rf_wdata, 0);
        chk("t1_pend", rs1_busy, 0);
        cyc(); cyc();
        reset = 1; rs1_addr = 0;
        cyc(); cyc();
        #1 chk("t1_flushed", rf_we, 0);
        ld_valid = 1; ld_rd = 6; ld_data = 32'h66;
        cyc(); ld_valid = 0;
        cyc();
        #1;
        chk("t1_post_we", rf_we, 1);
        chk("t1_post_a", rf_waddr, 6);

        // Random phase
        cyc();
        for (int n = 0; n < 3000; n++) begin
            rf_rdata1_i = $urandom;
            rf_rdata2_i = $urandom;
            issue_rd    = 5'($urandom_range(0, 31));
            issue_valid = $urandom_range(0, 2) == 0;
            if (m_we && m_load && m_waddr == issue_rd)
                issue_valid = 0;
            if (issue_valid && issue_rd != 0 && !m_pend[issue_rd])
                outst.push_back(issue_rd);
            ld_valid = $urandom_range(0, 1) == 1;
            ld_data  = $urandom;
            ld_rd    = 5'($urandom_range(0, 31));
            if (ld_valid && m_q.size() < DEPTH) begin
                if (outst.size() > 0 && $urandom_range(0, 7) != 0) begin
                    int k;
                    k = $urandom_range(0, outst.size() - 1);
                    ld_rd = outst[k];
                    outst.delete(k);
                end else if (m_pend[ld_rd]) begin
                    ld_rd = 0;
                end
            end
            alu_valid = $urandom_range(0, 2) == 0;
            alu_rd    = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            rs1_addr  = 5'($urandom_range(0, 31));
            rs2_addr  = 5'($urandom_range(0, 31));
            if (outst.size() > 0 && $urandom_range(0, 1) == 1)
                rs1_addr = outst[0];
            cyc();
        end
        idle();
        repeat (10) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
